// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg: alu_control codes and muldiv state encoding shared by the ALU and its control decoder
package riscv_alu_pkg;
    localparam logic [3:0] ALU_MUL = 4'b1011;
    localparam logic [3:0] ALU_DIV = 4'b1100;
    localparam logic [3:0] ALU_REM = 4'b1101;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;
endpackage

// File: rtl/riscv_muldiv_unit_if.sv
// riscv_muldiv_if: start/busy/done handshake and operand/result bus of the muldiv unit
interface riscv_muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master(output start, alu_control, op_a, op_b, input busy, done, result);
    modport slave(input start, alu_control, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative shift-add multiplier and restoring signed divider on one shared datapath
module riscv_muldiv_unit
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    riscv_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    muldiv_state_t   state, state_nxt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] opnd;
    logic [CW-1:0]   cnt;
    logic            is_mul, is_div, neg_q, neg_r;
    logic [XLEN-1:0] result;
    logic            valid_op, accept, div_zero, div_ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, min_int, fix_q, fix_r, special_res;
    logic [XLEN:0]   mul_sum, rem_shift, trial;
    always_comb begin
        valid_op    = bus.alu_control == ALU_MUL || bus.alu_control == ALU_DIV || bus.alu_control == ALU_REM;
        accept      = bus.start && valid_op && (state == IDLE || state == DONE);
        min_int     = {1'b1, {(XLEN-1){1'b0}}};
        div_zero    = bus.op_b == '0;
        div_ovf     = bus.op_a == min_int && &bus.op_b;
        special     = accept && bus.alu_control != ALU_MUL && (div_zero || div_ovf);
        special_res = div_zero ? (bus.alu_control == ALU_DIV ? '1 : bus.op_a)
                               : (bus.alu_control == ALU_DIV ? bus.op_a : '0);
        abs_a       = bus.op_a[XLEN-1] ? -bus.op_a : bus.op_a;
        abs_b       = bus.op_b[XLEN-1] ? -bus.op_b : bus.op_b;
        mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc[0]}} & opnd};
        // the dividend shifts out of acc's low half while quotient bits shift in
        rem_shift   = {rem, acc[XLEN-1]};
        trial       = rem_shift - {1'b0, opnd};
        fix_q       = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        fix_r       = neg_r ? -rem : rem;
        state_nxt   = state == CALC ? (cnt == '0 ? FIX : CALC)
                    : state == FIX  ? DONE
                    : accept        ? (special ? DONE : CALC)
                    : IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            rem    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            is_mul <= 1'b0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (accept) begin
            is_mul <= bus.alu_control == ALU_MUL;
            is_div <= bus.alu_control == ALU_DIV;
            neg_q  <= bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1];
            neg_r  <= bus.op_a[XLEN-1];
            cnt    <= CW'(XLEN-1);
            rem    <= '0;
            acc    <= {{XLEN{1'b0}}, bus.alu_control == ALU_MUL ? bus.op_b : abs_a};
            opnd   <= bus.alu_control == ALU_MUL ? bus.op_a : abs_b;
            if (special) result <= special_res;
        end else if (state == CALC) begin
            cnt <= cnt - 1'b1;
            if (is_mul) acc <= {mul_sum, acc[XLEN-1:1]};
            else begin
                rem             <= trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
                acc[XLEN-1:0]   <= {acc[XLEN-2:0], ~trial[XLEN]};
            end
        end else if (state == FIX) begin
            result <= is_mul ? acc[XLEN-1:0] : is_div ? fix_q : fix_r;
        end
    end
    assign bus.busy   = state == CALC || state == FIX;
    assign bus.done   = state == DONE;
    assign bus.result = result;
endmodule
